// File: rtl/masked_tbl_loader.sv
// Sequential writer for one masked S-box BRAM: streams bytes in and keeps a 16-bit running sum.
// Optional feature macro LOADER_VERIFY_EN adds a full-table readback that checks that sum.
module masked_tbl_loader #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       sum
);
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, VERIFY, WAIT, DONE, ERR} state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'((1 << ADDR_W) - 1);

  state_t            state, state_n;
  logic [ADDR_W:0]   wcnt;
  logic              hs, start_ok, rd_issue;
  logic [ADDR_W-1:0] rd_addr;

  assign hs       = s_valid & s_ready;
  assign start_ok = start & (state == IDLE || state == DONE || state == ERR);

`ifdef LOADER_VERIFY_EN
  localparam int              WC_W  = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1 << ADDR_W);

  logic [ADDR_W:0] rcnt;
  logic [RD_LAT-1:0] rd_pipe;
  logic [WC_W-1:0] wait_cnt;
  logic [15:0]     chk_sum, chk_final;

  assign rd_issue = (state_n == VERIFY);
  assign rd_addr  = rcnt[ADDR_W-1:0];
  // The final read beat arrives in the cycle WAIT decides, so it is folded in before the compare.
  assign chk_final = chk_sum + (rd_pipe[RD_LAT-1] ? {8'h00, mem_dout} : 16'h0000);
`else
  logic unused_dout;
  assign unused_dout = ^mem_dout;
  assign rd_issue    = 1'b0;
  assign rd_addr     = '0;
  assign err         = 1'b0;
`endif

  always_comb begin
    // NOTE: default assigned first so no path through this block infers a latch.
    state_n = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_n = LOAD;
      LOAD:            if (hs && wcnt == LAST_IDX) state_n = DRAIN;
`ifdef LOADER_VERIFY_EN
      DRAIN:           state_n = VERIFY;
      VERIFY:          if (rcnt == DEPTH) state_n = WAIT;
      WAIT:            if (wait_cnt == WC_W'(RD_LAT - 1))
                         state_n = (chk_final == sum) ? DONE : ERR;
`else
      DRAIN:           state_n = DONE;
`endif
      default:         state_n = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      s_ready  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wcnt     <= '0;
      sum      <= '0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      state    <= state_n;
      s_ready  <= (state_n == LOAD);
      busy     <= (state_n inside {LOAD, DRAIN, VERIFY, WAIT});
      done     <= (state_n == DONE);
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      if (start_ok) begin
        wcnt <= '0;
        sum  <= '0;
      end else if (hs) begin
        wcnt     <= wcnt + 1'b1;
        sum      <= sum + {8'h00, s_data};
        mem_en   <= 1'b1;
        mem_we   <= 1'b1;
        mem_addr <= wcnt[ADDR_W-1:0];
        mem_din  <= s_data;
      end else if (rd_issue) begin
        mem_en   <= 1'b1;
        mem_addr <= rd_addr;
      end
    end
  end

`ifdef LOADER_VERIFY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt     <= '0;
      rd_pipe  <= '0;
      wait_cnt <= '0;
      chk_sum  <= '0;
      err      <= 1'b0;
    end else begin
      err      <= (state_n == ERR);
      // Tracks which bus cycles were reads so returning data is matched RD_LAT cycles later.
      rd_pipe  <= (rd_pipe << 1) | RD_LAT'(mem_en & ~mem_we);
      wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      if (start_ok) begin
        rcnt    <= '0;
        chk_sum <= '0;
      end else begin
        if (rd_issue)           rcnt    <= rcnt + 1'b1;
        if (rd_pipe[RD_LAT-1])  chk_sum <= chk_final;
      end
    end
  end
`endif
endmodule
